dcache_assoc_ctrl: RTL

//  Parametrised set-associative data cache with miss-handling FSM for the MEMORY stage.

---
 rtl/dcache_assoc_ctrl_if.sv | 33 +++
 rtl/dcache_assoc_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dcache_assoc_ctrl_if.sv
// Pipeline-side and backing-memory-side signals of the data cache.
// The cache uses the slave modport; the requester/memory side uses master.
interface dcache_assoc_ctrl_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     cpu_req;
  logic                     cpu_we;
  logic [ADDRESS_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0]    cpu_wdata;
  logic [DATA_WIDTH-1:0]    cpu_rdata;
  logic                     cpu_ready;
  logic                     mem_req;
  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic [DATA_WIDTH-1:0]    mem_rdata;
  logic                     mem_ack;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/dcache_assoc_ctrl.sv
// Set-associative (1 or 2 way) write-through, no-write-allocate data cache
// with a miss-handling FSM. One word per line, LRU replacement for 2 ways.
// Read hits complete combinationally; misses and stores stall via cpu_ready.
// Optional macro DCACHE_STATS_EN adds saturating hit/miss counters.
module dcache_assoc_ctrl #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int SET_BITS      = 3,
  parameter int WAYS          = 2
) (
  input  logic clk,
  input  logic rst,
  dcache_assoc_ctrl_if.slave bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int SETS  = 1 << SET_BITS;
  localparam int TAG_W = ADDRESS_WIDTH - SET_BITS - 2;

  typedef enum logic [1:0] {IDLE, RMISS, WTHRU, DONE} cacheState_t;

  cacheState_t stateReg, stateNext;

  logic [SET_BITS-1:0]   setIdx;
  logic [TAG_W-1:0]      reqTag;
  logic [WAYS-1:0]       wayHit, wayValid, victimOh, lruOh, fillWe, storeWe;
  logic [DATA_WIDTH-1:0] wayData [WAYS];
  logic [DATA_WIDTH-1:0] hitData, rdataQ, rdataNow;
  logic                  anyHit, readyNow, memReqNow, memWeNow;
  logic                  fillEn, storeEn, hitTouch;

  assign setIdx = bus.cpu_addr[SET_BITS+1:2];
  assign reqTag = bus.cpu_addr[ADDRESS_WIDTH-1:SET_BITS+2];

  // Per-way storage. Reads are asynchronous so a hit can complete in the
  // request cycle; tag and data words carry no reset, only valid bits do.
  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : gWay
      logic                  validMem [SETS];
      logic [TAG_W-1:0]      tagMem   [SETS];
      logic [DATA_WIDTH-1:0] dataMem  [SETS];

      assign wayValid[gi] = validMem[setIdx];
      assign wayHit[gi]   = validMem[setIdx] && (tagMem[setIdx] == reqTag);
      assign wayData[gi]  = dataMem[setIdx];
      assign fillWe[gi]   = fillEn && victimOh[gi];
      assign storeWe[gi]  = storeEn && wayHit[gi];

      // Valid bits: cleared on reset, set when this way is filled.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int s = 0; s < SETS; s++) validMem[s] <= 1'b0;
        end else if (fillWe[gi]) begin
          validMem[setIdx] <= 1'b1;
        end
      end

      // Tag/data: miss fill writes both; a store hit updates the word only.
      always_ff @(posedge clk) begin
        if (fillWe[gi]) begin
          tagMem[setIdx]  <= reqTag;
          dataMem[setIdx] <= bus.mem_rdata;
        end else if (storeWe[gi]) begin
          dataMem[setIdx] <= bus.cpu_wdata;
        end
      end
    end

    if (WAYS == 2) begin : gLru
      // lruMem holds the index of the way to evict next in each set.
      logic lruMem [SETS];

      assign lruOh = lruMem[setIdx] ? 2'b10 : 2'b01;

      // Point LRU at the way not just touched (hit, store hit or fill).
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int s = 0; s < SETS; s++) lruMem[s] <= 1'b0;
        end else if (hitTouch || (storeEn && anyHit)) begin
          lruMem[setIdx] <= ~wayHit[1];
        end else if (fillEn) begin
          lruMem[setIdx] <= ~victimOh[1];
        end
      end
    end else begin : gDirect
      assign lruOh = '1;
    end
  endgenerate

  // Hit data mux and victim choice: first invalid way (way 0 first), else LRU.
  always_comb begin
    logic found;
    hitData  = '0;
    victimOh = '0;
    found    = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (wayHit[w]) hitData = hitData | wayData[w];
      if (!wayValid[w] && !found) begin
        victimOh[w] = 1'b1;
        found       = 1'b1;
      end
    end
    if (!found) victimOh = lruOh;
  end

  assign anyHit = |wayHit;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stateReg <= IDLE;
    else     stateReg <= stateNext;
  end

  // Next-state and handshake outputs.
  always_comb begin
    stateNext = stateReg;
    readyNow  = 1'b0;
    rdataNow  = '0;
    memReqNow = 1'b0;
    memWeNow  = 1'b0;
    fillEn    = 1'b0;
    storeEn   = 1'b0;
    hitTouch  = 1'b0;
    case (stateReg)
      IDLE: begin
        if (bus.cpu_req) begin
          if (bus.cpu_we) begin
            stateNext = WTHRU;
          end else if (anyHit) begin
            readyNow = 1'b1;
            rdataNow = hitData;
            hitTouch = 1'b1;
          end else begin
            stateNext = RMISS;
          end
        end
      end
      RMISS: begin
        memReqNow = 1'b1;
        if (bus.mem_ack) begin
          fillEn    = 1'b1;
          stateNext = DONE;
        end
      end
      WTHRU: begin
        memReqNow = 1'b1;
        memWeNow  = 1'b1;
        if (bus.mem_ack) begin
          storeEn   = 1'b1;
          stateNext = DONE;
        end
      end
      DONE: begin
        readyNow  = 1'b1;
        rdataNow  = rdataQ;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Load result held for the DONE cycle; a store leaves zero there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          rdataQ <= '0;
    else if (fillEn)  rdataQ <= bus.mem_rdata;
    else if (storeEn) rdataQ <= '0;
  end

  assign bus.cpu_ready = readyNow;
  assign bus.cpu_rdata = rdataNow;
  assign bus.mem_req   = memReqNow;
  assign bus.mem_we    = memWeNow;
  assign bus.mem_addr  = bus.cpu_addr;
  assign bus.mem_wdata = bus.cpu_wdata;

`ifdef DCACHE_STATS_EN
  logic missEvent;
  assign missEvent = (stateReg == IDLE) && bus.cpu_req && !bus.cpu_we && !anyHit;

  // Saturating hit/miss counters for loads decided in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hitTouch && (hit_cnt != 32'hFFFF_FFFF))   hit_cnt  <= hit_cnt + 32'd1;
      if (missEvent && (miss_cnt != 32'hFFFF_FFFF)) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule
